// File: rtl/hpi_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module : hpi_bus_master_pkg
// Brief  : FSM state encodings, HPI register addresses and a sizing helper
//          shared by the HPI bus master and its testbench.
// Rev    : 1.0  initial release
// ============================================================================
package hpi_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_RST_WAIT = 3'd1,
    ST_IDLE     = 3'd2,
    ST_SETUP    = 3'd3,
    ST_STROBE   = 3'd4,
    ST_HOLD     = 3'd5,
    ST_RECOVER  = 3'd6
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpi_bus_master_irq_sync.sv
`default_nettype none
// ============================================================================
// Module : hpi_irq_sync
// Brief  : Two-flop synchroniser plus rising-edge detect for async inputs.
// Rev    : 1.0  initial release
// ============================================================================
module hpi_irq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] level_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/hpi_bus_master.sv
`default_nettype none
// ============================================================================
// Module : hpi_bus_master
// Brief  : Single-clock CY7C67300 HPI bus master with programmable access
//          timing, chip-reset sequencing and INT synchronisation.
// Rev    : 1.0  initial release
// ============================================================================
module hpi_bus_master
  import hpi_bus_master_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 16,
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 6,
  parameter int HOLD_CYC     = 2,
  parameter int TURN_CYC     = 4,
  parameter int RST_HOLD_CYC = 1000,
  parameter int RST_WAIT_CYC = 50000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_pin,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              chip_reset_req,
  output logic              busy,
  output logic              irq_level,
  output logic              irq_rise,
  output logic              hpi_resetn,
  output logic              hpi_csn,
  output logic              hpi_oen,
  output logic              hpi_wen,
  output logic [ADDR_W-1:0] hpi_address,
  output logic [DATA_W-1:0] hpi_data_o,
  output logic              hpi_data_oe,
  input  logic [DATA_W-1:0] hpi_data_i,
  input  logic              hpi_irq
);

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, TURN_CYC)),
                                max2(RST_HOLD_CYC, RST_WAIT_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP    = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_STROBE   = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD     = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_TURN     = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RST_HOLD = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RST_WAIT = CNT_W'(RST_WAIT_CYC - 1);

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || TURN_CYC < 1) begin : g_bad_cycle_param
    $error("hpi_bus_master: SETUP/STROBE/HOLD/TURN cycle counts must be >= 1");
  end

  hpi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_dec;
  logic              last_cyc;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pend_q, pend_d;
  logic              rsp_q, rsp_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              resetn_q, resetn_d;
  logic              csn_q, csn_d;
  logic              oen_q, oen_d;
  logic              wen_q, wen_d;
  logic              oe_q, oe_d;
  logic              access_nxt;

  assign cnt_dec  = cnt_q - 1'b1;
  assign last_cyc = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_dec;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    pend_d  = pend_q;
    rsp_d   = 1'b0;

    unique case (state_q)
      ST_RST_HOLD: if (last_cyc) begin state_d = ST_RST_WAIT; cnt_d = LD_RST_WAIT; end
      ST_RST_WAIT: if (last_cyc) state_d = ST_IDLE;
      ST_IDLE: begin
        cnt_d = cnt_q;
        // A pending or coincident chip reset wins over a new request.
        if (pend_q || chip_reset_req) begin
          state_d = ST_RST_HOLD;
          cnt_d   = LD_RST_HOLD;
          pend_d  = 1'b0;
        end else if (req_valid) begin
          state_d = ST_SETUP;
          cnt_d   = LD_SETUP;
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ST_SETUP:  if (last_cyc) begin state_d = ST_STROBE; cnt_d = LD_STROBE; end
      ST_STROBE: if (last_cyc) begin
        state_d = ST_HOLD;
        cnt_d   = LD_HOLD;
        if (!wr_q) rdata_d = hpi_data_i;
      end
      ST_HOLD: if (last_cyc) begin
        state_d = ST_RECOVER;
        cnt_d   = LD_TURN;
        rsp_d   = 1'b1;
      end
      ST_RECOVER: if (last_cyc) state_d = ST_IDLE;
      default: begin state_d = ST_RST_HOLD; cnt_d = LD_RST_HOLD; end
    endcase

    if (chip_reset_req && (state_q inside {ST_SETUP, ST_STROBE, ST_HOLD, ST_RECOVER}))
      pend_d = 1'b1;

    // Pad controls are decoded from the next state so the flops track the state.
    access_nxt = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD};
    resetn_d   = (state_d != ST_RST_HOLD);
    csn_d      = !access_nxt;
    oen_d      = !((state_d == ST_STROBE) && !wr_d);
    wen_d      = !((state_d == ST_STROBE) && wr_d);
    oe_d       = access_nxt && wr_d;
    busy_d     = (state_d != ST_IDLE);
    ready_d    = (state_d == ST_IDLE) && !pend_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_pin) begin
    if (!sys_rst_pin) begin
      state_q  <= ST_RST_HOLD;
      cnt_q    <= LD_RST_HOLD;
      wr_q     <= 1'b0;
      addr_q   <= ADDR_W'(HPI_DATA);
      wdata_q  <= '0;
      rdata_q  <= '0;
      pend_q   <= 1'b0;
      rsp_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      resetn_q <= 1'b0;
      csn_q    <= 1'b1;
      oen_q    <= 1'b1;
      wen_q    <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      pend_q   <= pend_d;
      rsp_q    <= rsp_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      resetn_q <= resetn_d;
      csn_q    <= csn_d;
      oen_q    <= oen_d;
      wen_q    <= wen_d;
      oe_q     <= oe_d;
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_q;
  assign rsp_rdata   = rdata_q;
  assign busy        = busy_q;
  assign hpi_resetn  = resetn_q;
  assign hpi_csn     = csn_q;
  assign hpi_oen     = oen_q;
  assign hpi_wen     = wen_q;
  assign hpi_address = addr_q;
  assign hpi_data_o  = wdata_q;
  assign hpi_data_oe = oe_q;

  hpi_irq_sync #(.W(1)) u_irq_sync (
    .clk     (sys_clk),
    .rst_n   (sys_rst_pin),
    .async_i (hpi_irq),
    .level_o (irq_level),
    .rise_o  (irq_rise)
  );

endmodule
`default_nettype wire

// File: tb/tb_hpi_bus_master.sv
`default_nettype none
// ============================================================================
// Module : tb_hpi_bus_master
// Brief  : Directed, table-driven bench for hpi_bus_master.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hpi_bus_master;
  import hpi_bus_master_pkg::*;

  localparam int RH = 8;
  localparam int RW = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, chip_reset_req = 1'b0, hpi_irq = 1'b0;
  logic [1:0]  req_addr = '0;
  logic [15:0] req_wdata = '0, model_rdata = '0;
  logic        req_ready, rsp_valid, busy, irq_level, irq_rise;
  logic        hpi_resetn, hpi_csn, hpi_oen, hpi_wen, hpi_data_oe;
  logic [1:0]  hpi_address;
  logic [15:0] rsp_rdata, hpi_data_o, hpi_data_i;

  always #5 clk = ~clk;

  // Chip model: drives read data only while nRD is low.
  assign hpi_data_i = hpi_oen ? 16'h0000 : model_rdata;

  hpi_bus_master #(.RST_HOLD_CYC(RH), .RST_WAIT_CYC(RW)) dut (
    .sys_clk(clk), .sys_rst_pin(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .chip_reset_req(chip_reset_req), .busy(busy),
    .irq_level(irq_level), .irq_rise(irq_rise),
    .hpi_resetn(hpi_resetn), .hpi_csn(hpi_csn), .hpi_oen(hpi_oen), .hpi_wen(hpi_wen),
    .hpi_address(hpi_address), .hpi_data_o(hpi_data_o), .hpi_data_oe(hpi_data_oe),
    .hpi_data_i(hpi_data_i), .hpi_irq(hpi_irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " resetn"}, 32'(hpi_resetn), 0);
    check({tag, " csn"},    32'(hpi_csn), 1);
    check({tag, " oen"},    32'(hpi_oen), 1);
    check({tag, " wen"},    32'(hpi_wen), 1);
    check({tag, " oe"},     32'(hpi_data_oe), 0);
    check({tag, " addr"},   32'(hpi_address), 0);
    check({tag, " data_o"}, 32'(hpi_data_o), 0);
    check({tag, " ready"},  32'(req_ready), 0);
    check({tag, " rsp"},    32'(rsp_valid), 0);
    check({tag, " rdata"},  32'(rsp_rdata), 0);
    check({tag, " busy"},   32'(busy), 1);
    check({tag, " irq"},    32'({irq_level, irq_rise}), 0);
  endtask

  // Releases reset at a falling edge and measures the chip reset sequence.
  task automatic release_and_measure(input string tag);
    int lo, wt, rsp_n;
    lo = 0; wt = 0; rsp_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    while (!hpi_resetn && lo < 1000) begin
      lo++;
      if (rsp_valid) rsp_n++;
      @(negedge clk);
    end
    while (!req_ready && wt < 1000) begin
      if (!hpi_resetn) lo++;
      if (rsp_valid) rsp_n++;
      wt++;
      @(negedge clk);
    end
    check({tag, " resetn low cycles"}, 32'(lo), RH);
    check({tag, " wait cycles"}, 32'(wt), RW);
    check({tag, " busy in idle"}, 32'(busy), 0);
    check({tag, " no rsp"}, 32'(rsp_n), 0);
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!req_ready && t < 500) begin t++; @(negedge clk); end
    check({tag, " ready"}, 32'(req_ready), 1);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] model;
    int          csn_lo;
    int          oen_lo;
    int          wen_lo;
    int          oe_hi;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int csn_lo, oen_lo, wen_lo, oe_hi, oe_bad, first_stb, both, addr_bad, data_bad;
    int rsp_cyc, rsp_n, ready_cyc, acc1, acc2, rsp1, gap, nacc, rfirst, rlo, ready15, lat, rises;
    string tg;

    vecs[0] = '{1'b1, HPI_ADDRESS, 16'h1000, 16'h0000, 10, 0, 6, 10, 16'h0000};
    vecs[1] = '{1'b0, HPI_DATA,    16'h0000, 16'hBEEF, 10, 6, 0,  0, 16'hBEEF};
    vecs[2] = '{1'b1, HPI_STATUS,  16'hA5A5, 16'h1111, 10, 0, 6, 10, 16'hBEEF};
    vecs[3] = '{1'b0, HPI_MAILBOX, 16'h5A5A, 16'h1234, 10, 6, 0,  0, 16'h1234};
    vecs[4] = '{1'b1, HPI_DATA,    16'hFFFF, 16'h0000, 10, 0, 6, 10, 16'h1234};

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    release_and_measure("por");

    // Single accesses from the table; cycle 0 is the acceptance cycle.
    foreach (vecs[i]) begin
      tg = $sformatf("vec%0d", i);
      wait_ready(tg);
      model_rdata = vecs[i].model;
      csn_lo = 0; oen_lo = 0; wen_lo = 0; oe_hi = 0; oe_bad = 0; first_stb = -1;
      both = 0; addr_bad = 0; data_bad = 0; rsp_cyc = -1; rsp_n = 0; ready_cyc = -1;
      for (int k = 0; k <= 20; k++) begin
        if (k > 0) begin
          if (!hpi_csn) csn_lo++;
          if (!hpi_oen) oen_lo++;
          if (!hpi_wen) wen_lo++;
          if (!hpi_oen && !hpi_wen) both++;
          if ((!hpi_oen || !hpi_wen) && first_stb < 0) first_stb = k;
          if (hpi_data_oe) oe_hi++;
          if (hpi_data_oe && hpi_csn) oe_bad++;
          if (!hpi_csn && hpi_address !== vecs[i].addr) addr_bad++;
          if (hpi_data_oe && hpi_data_o !== vecs[i].wdata) data_bad++;
          if (rsp_valid) begin rsp_n++; if (rsp_cyc < 0) rsp_cyc = k; end
          if (req_ready && ready_cyc < 0) ready_cyc = k;
        end
        req_valid = (k == 0);
        req_write = vecs[i].wr;
        req_addr  = vecs[i].addr;
        req_wdata = vecs[i].wdata;
        @(negedge clk);
      end
      check({tg, " csn low"}, 32'(csn_lo), 32'(vecs[i].csn_lo));
      check({tg, " oen low"}, 32'(oen_lo), 32'(vecs[i].oen_lo));
      check({tg, " wen low"}, 32'(wen_lo), 32'(vecs[i].wen_lo));
      check({tg, " oe high"}, 32'(oe_hi), 32'(vecs[i].oe_hi));
      check({tg, " oe outside csn"}, 32'(oe_bad), 0);
      check({tg, " strobe start"}, 32'(first_stb), 3);
      check({tg, " rd and wr low"}, 32'(both), 0);
      check({tg, " address"}, 32'(addr_bad), 0);
      check({tg, " data_o"}, 32'(data_bad), 0);
      check({tg, " rsp cycle"}, 32'(rsp_cyc), 11);
      check({tg, " rsp count"}, 32'(rsp_n), 1);
      check({tg, " ready cycle"}, 32'(ready_cyc), 15);
      check({tg, " rdata"}, 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
    end

    // Back-to-back requests with valid held high.
    wait_ready("b2b");
    acc1 = -1; acc2 = -1; rsp1 = -1; gap = 0; nacc = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        if (rsp_valid && rsp1 < 0) rsp1 = k;
        if (rsp1 >= 0 && acc2 < 0 && !hpi_csn) gap++;
      end
      req_valid = (nacc < 2);
      req_write = 1'b1;
      req_addr  = HPI_DATA;
      req_wdata = 16'h0100 + 16'(k);
      if (req_valid && req_ready) begin
        nacc++;
        if (nacc == 1) acc1 = k; else acc2 = k;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b first accept", 32'(acc1), 0);
    check("b2b first rsp", 32'(rsp1), 11);
    check("b2b turn gap", 32'(acc2 - rsp1), 4);
    check("b2b csn high gap", 32'(gap), 0);

    // Chip reset requested twice during a write's strobe, read queued behind it.
    wait_ready("crst");
    model_rdata = 16'hC0DE;
    acc1 = -1; acc2 = -1; rsp1 = -1; rsp_n = 0; rfirst = -1; rlo = 0; ready15 = -1;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) begin
        if (rsp_valid) begin rsp_n++; if (rsp1 < 0) rsp1 = k; end
        if (!hpi_resetn) begin rlo++; if (rfirst < 0) rfirst = k; end
        if (k == 15) ready15 = 32'(req_ready);
      end
      chip_reset_req = (k == 4) || (k == 6);
      req_valid = (k == 0) || (k >= 15 && acc2 < 0);
      req_write = (k == 0);
      req_addr  = HPI_MAILBOX;
      req_wdata = 16'h7777;
      if (req_valid && req_ready) begin
        if (k == 0) acc1 = k; else acc2 = k;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chip_reset_req = 1'b0;
    check("crst accept", 32'(acc1), 0);
    check("crst write rsp", 32'(rsp1), 11);
    check("crst ready after write", 32'(ready15), 0);
    check("crst resetn start", 32'(rfirst), 16);
    check("crst resetn low", 32'(rlo), RH);
    check("crst next accept", 32'(acc2), 16 + RH + RW);
    check("crst rsp count", 32'(rsp_n), 2);
    check("crst read data", 32'(rsp_rdata), 32'h0000C0DE);

    // Async reset asserted in the middle of a write strobe.
    wait_ready("arst");
    for (int k = 0; k <= 5; k++) begin
      req_valid = (k == 0);
      req_write = 1'b1;
      req_addr  = HPI_ADDRESS;
      req_wdata = 16'h2222;
      @(negedge clk);
    end
    check("arst pre wen", 32'(hpi_wen), 0);
    check("arst pre oe", 32'(hpi_data_oe), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst csn", 32'(hpi_csn), 1);
    check("arst wen", 32'(hpi_wen), 1);
    check("arst oen", 32'(hpi_oen), 1);
    check("arst oe", 32'(hpi_data_oe), 0);
    rsp_n = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) rsp_n++;
    end
    check("arst no rsp", 32'(rsp_n), 0);
    check_reset_vals("arst");
    release_and_measure("arst");

    // IRQ synchroniser latency and single rise pulse.
    lat = -1; rises = 0;
    hpi_irq = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (irq_level && lat < 0) lat = k;
      if (irq_rise) begin
        rises++;
        check("irq rise with level", 32'(k), 32'(lat));
      end
    end
    check("irq latency", 32'(lat >= 2 && lat <= 3), 1);
    check("irq rise pulses", 32'(rises), 1);
    hpi_irq = 1'b0;
    rises = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (irq_rise) rises++;
    end
    check("irq fall no rise", 32'(rises), 0);
    check("irq level low", 32'(irq_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
